// File: rtl/nios_system_sysid_pkg.sv
// Shared types and constants for the sysid checker and
// its bus-health helpers.
package nios_system_sysid_pkg;
  localparam int SYSID_DATA_W = 32;
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    BACKOFF,
    DONE
  } state_t;
endpackage

// File: rtl/nios_system_sysid_checker_if.sv
// Avalon-MM read-only master link between the checker
// and the sysid control slave.
interface nios_system_sysid_checker_if;
  import nios_system_sysid_pkg::*;

  logic                    avm_address;
  logic                    avm_read;
  logic                    avm_waitrequest;
  logic [SYSID_DATA_W-1:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );
endinterface

// File: rtl/nios_system_sysid_timeout.sv
// Stall counter: counts enabled cycles up to a loaded limit
// and flags expiry; clear restarts it for the next access.
module nios_system_sysid_timeout #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_expired
);
  logic [W-1:0] r_cnt;

  assign o_expired = (r_cnt == i_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + W'(1);
    end
  end
endmodule

// File: rtl/nios_system_sysid_checker.sv
// Reads sysid ID and timestamp words, compares them to expected
// values and publishes a bounded-time pass/fail verdict.
module nios_system_sysid_checker
  import nios_system_sysid_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1650897749,
  parameter int                      CHECK_TIMESTAMP    = 1,
  parameter int                      TIMEOUT_CYCLES     = 255,
  parameter int                      MAX_RETRIES        = 3,
  parameter int                      AUTO_START         = 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  nios_system_sysid_checker_if.master avm,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        id_ok,
  output logic                        ts_ok,
  output logic                        timeout_err,
  output logic [SYSID_DATA_W-1:0]     id_value,
  output logic [SYSID_DATA_W-1:0]     ts_value
);
  localparam logic [15:0] LP_TMO = 16'(TIMEOUT_CYCLES);
  localparam logic [3:0]  LP_MR  = 4'(MAX_RETRIES);
  localparam logic        LP_CHK = (CHECK_TIMESTAMP != 0);
  localparam logic        LP_AUTO = (AUTO_START != 0);

  state_t                  r_state;
  logic                    r_auto;
  logic                    r_read;
  logic                    r_addr;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_pass;
  logic                    r_id_ok;
  logic                    r_ts_ok;
  logic                    r_tmo;
  logic [3:0]              r_retry;
  logic [SYSID_DATA_W-1:0] r_id;
  logic [SYSID_DATA_W-1:0] r_ts;

  logic                    w_rd;
  logic                    w_ack;
  logic                    w_exp;
  logic                    w_abort;
  logic                    w_fin;
  logic                    w_id_ok;
  logic                    w_ts_ok;
  logic [SYSID_DATA_W-1:0] w_ts_src;

  assign w_rd    = (r_state == RD_ID) || (r_state == RD_TS);
  assign w_ack   = w_rd && !avm.avm_waitrequest;
  assign w_abort = w_rd && avm.avm_waitrequest && w_exp;
  assign w_fin   = ((r_state == RD_TS) && w_ack)
                || (w_abort && (r_retry >= LP_MR));

  // Verdict sees the timestamp word in the same cycle it lands
  assign w_ts_src = ((r_state == RD_TS) && w_ack)
                  ? avm.avm_readdata : r_ts;
  assign w_id_ok  = (r_id == EXPECTED_ID);
  assign w_ts_ok  = (w_ts_src == EXPECTED_TIMESTAMP);

  nios_system_sysid_timeout #(
    .W (16)
  ) u_tmo (
    .clk       (clock),
    .rst_n     (reset_n),
    .i_clear   (!w_rd || w_ack),
    .i_en      (w_rd && avm.avm_waitrequest),
    .i_limit   (LP_TMO),
    .o_expired (w_exp)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_auto  <= LP_AUTO;
      r_read  <= 1'b0;
      r_addr  <= SYSID_ADDR_ID;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_id_ok <= 1'b0;
      r_ts_ok <= 1'b0;
      r_tmo   <= 1'b0;
      r_retry <= '0;
      r_id    <= '0;
      r_ts    <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start || r_auto) begin
            r_auto  <= 1'b0;
            r_retry <= '0;
            r_busy  <= 1'b1;
            r_read  <= 1'b1;
            r_addr  <= SYSID_ADDR_ID;
            r_state <= RD_ID;
          end
        end
        RD_ID, RD_TS: begin
          if (w_ack && (r_state == RD_ID)) begin
            r_id    <= avm.avm_readdata;
            r_addr  <= SYSID_ADDR_TS;
            r_state <= RD_TS;
          end else if (w_ack) begin
            r_ts    <= avm.avm_readdata;
            r_read  <= 1'b0;
            r_state <= DONE;
          end else if (w_abort) begin
            r_read <= 1'b0;
            if (r_retry < LP_MR) begin
              r_retry <= r_retry + 4'd1;
              r_state <= BACKOFF;
            end else begin
              r_state <= DONE;
            end
          end
        end
        BACKOFF: begin
          r_read  <= 1'b1;
          r_state <= (r_addr == SYSID_ADDR_TS) ? RD_TS : RD_ID;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_fin) begin
        r_done  <= 1'b1;
        r_id_ok <= w_id_ok;
        r_ts_ok <= w_ts_ok;
        r_tmo   <= w_abort;
        r_pass  <= !w_abort && w_id_ok && (w_ts_ok || !LP_CHK);
      end
    end
  end

  assign avm.avm_read    = r_read;
  assign avm.avm_address = r_addr;
  assign busy            = r_busy;
  assign done            = r_done;
  assign pass            = r_pass;
  assign id_ok           = r_id_ok;
  assign ts_ok           = r_ts_ok;
  assign timeout_err     = r_tmo;
  assign id_value        = r_id;
  assign ts_value        = r_ts;
endmodule
